inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Reverse of the core's immediate/field decode path.
- Accepts a structured RV32I instruction description (format, opcode, register fields, funct fields, signed immediate) and packs it into a 32-bit instruction word.
- Flags any immediate that cannot be represented in the selected format.
- Each emitted word carries an auto-incrementing word address for streaming into instruction memory (boot/program loader, self-test generator).
- Two-stage valid/ready pipeline with full backpressure.

Parameters:
- ADDR_W, 10, width of the output word-address counter.
- BASE_ADDR, 0, counter value after reset and after clr.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_fmt  in  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=I-shift, 7=reserved.
- in_opcode  in  7  inst[6:0].
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  inst[14:12].
- in_funct7  in  7  inst[31:25] for R and I-shift.
- in_imm  in  32  signed byte-offset/value, unencoded.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer ready.
- out_inst  out  32  encoded instruction.
- out_addr  out  ADDR_W  word address of out_inst.
- out_err  out  1  immediate not representable, or reserved fmt.
- clr  in  1  synchronous address-counter clear.

Behaviour:
- Reset (async assert, sync-safe release):
  - s1_valid=0, out_valid=0, out_inst=0, out_err=0.
  - Address counter=BASE_ADDR.
  - in_ready=1 once rst_n is high.
- Stage 1 (S1): registers the request and computes the range check.
- Stage 2 (S2): registers packed out_inst/out_err.
- Pipeline advance and flow control:
  - S2 loads when S2 is empty or (out_valid && out_ready).
  - S1 advances into S2 under the same condition.
  - in_ready = !s1_valid || S2 loading.
- Latency: 2 cycles from accept to out_valid when unstalled; throughput 1 word/cycle.
- While out_valid && !out_ready: out_inst, out_addr and out_err are held stable. No drops, no duplicates, order preserved.
- Packing (standard RV32I field placement):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - I-shift: {funct7, imm[4:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Range rules (in_imm treated as signed 32-bit); out_err=1 if violated:
  - I/S: -2048..2047.
  - B: -4096..4094 and imm[0]=0.
  - J: -1048576..1048574 and imm[0]=0.
  - U: imm[11:0]=0.
  - I-shift: imm[31:5]=0.
  - R: immediate ignored, err=0.
- On error the word is still packed from the truncated bits (no substitution).
- fmt=7: out_inst=0, out_err=1.
- Unused fields are ignored and never leak into out_inst.
- Address counter:
  - out_addr shows the current counter value.
  - Increments by 1 on each output handshake and wraps modulo 2^ADDR_W with no flag.
  - clr loads BASE_ADDR next cycle; clr wins over a simultaneous handshake. clr does not flush S1/S2.
- rst_n asserted mid-operation: all in-flight words discarded immediately, outputs return to reset values.

Decomposition:
- Shared package:
  - Format enum FMT_R..FMT_RSVD.
  - Opcode constants (OP_IMM 7'h13, LOAD 7'h03, STORE 7'h23, BRANCH 7'h63, LUI 7'h37, JAL 7'h6F).
  - Immediate min/max constants per format.
- One combinational sub-module, inst_pack (fmt, fields, imm → inst, err), instantiated between S1 and S2.
- Pipeline, handshake and counter logic stay in inst_encoder.

Test Plan:
- I-type, then S-type, back-to-back with out_ready=1:
  - I-type: fmt=1, op=0x13, rd=1, rs1=0, f3=0, imm=0xFFFFFFFF → out_inst=0xFFF00093, err=0, addr=0, 2 cycles after accept.
  - S-type: fmt=2, op=0x23, rs1=3, rs2=2, f3=2, imm=8 → 0x0021A423, addr=1.
- Branch/jump/upper:
  - B: fmt=3, op=0x63, rs1=rs2=0, imm=-4 → 0xFE000EE3.
  - J: fmt=5, op=0x6F, rd=1, imm=2048 → 0x001000EF.
  - U: fmt=4, op=0x37, rd=5, imm=0x12345000 → 0x123452B7.
  - All err=0.
- Errors:
  - I imm=2048 (op=0x13, regs 0) → 0x80000013, err=1.
  - B imm=3 → err=1.
  - U imm=0x12345001 → err=1.
  - fmt=7 → out_inst=0, err=1.
- Backpressure: three requests offered, out_ready=0 for 5 cycles:
  - in_ready falls after 2 accepts.
  - out_inst/out_addr stable throughout.
  - On release, words drain in order at addrs 0,1,2.
- Counter:
  - ADDR_W=2, 5 handshakes → addrs 0,1,2,3,0.
  - clr asserted during a handshake → next out_addr=BASE_ADDR, pipeline contents preserved.
- Reset mid-stream: assert rst_n=0 with S1 and S2 full → out_valid=0, out_inst=0, out_addr=BASE_ADDR immediately; first post-reset word appears at addr 0.

Source files
------------

// File: rtl/inst_encoder_pkg.sv
// inst_encoder_pkg: shared formats, opcodes, immediate limits and request type for the RV32I encoder.
package inst_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_ISH  = 3'd6,
    FMT_RSVD = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  localparam int IS_MIN = -2048;
  localparam int IS_MAX = 2047;
  localparam int B_MIN  = -4096;
  localparam int B_MAX  = 4094;
  localparam int J_MIN  = -1048576;
  localparam int J_MAX  = 1048574;

  typedef struct packed {
    fmt_e        fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } req_t;

  function automatic logic in_range(input logic [31:0] imm, input int lo, input int hi);
    return $signed(imm) >= lo && $signed(imm) <= hi;
  endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// inst_pack: combinational RV32I field packer with immediate range check.
module inst_pack
  import inst_encoder_pkg::*;
(
  input  req_t        req_i,
  output logic [31:0] inst_o,
  output logic        err_o
);

  logic [31:0] imm;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7, op;

  assign imm = req_i.imm;
  assign rd  = req_i.rd;
  assign rs1 = req_i.rs1;
  assign rs2 = req_i.rs2;
  assign f3  = req_i.funct3;
  assign f7  = req_i.funct7;
  assign op  = req_i.opcode;

  // Out-of-range immediates are still packed from their truncated bits.
  always_comb begin
    inst_o = '0;
    err_o  = 1'b0;
    case (req_i.fmt)
      FMT_R:   inst_o = {f7, rs2, rs1, f3, rd, op};
      FMT_I: begin
        inst_o = {imm[11:0], rs1, f3, rd, op};
        err_o  = !in_range(imm, IS_MIN, IS_MAX);
      end
      FMT_ISH: begin
        inst_o = {f7, imm[4:0], rs1, f3, rd, op};
        err_o  = |imm[31:5];
      end
      FMT_S: begin
        inst_o = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        err_o  = !in_range(imm, IS_MIN, IS_MAX);
      end
      FMT_B: begin
        inst_o = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        err_o  = !in_range(imm, B_MIN, B_MAX) || imm[0];
      end
      FMT_U: begin
        inst_o = {imm[31:12], rd, op};
        err_o  = |imm[11:0];
      end
      FMT_J: begin
        inst_o = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        err_o  = !in_range(imm, J_MIN, J_MAX) || imm[0];
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: two-stage valid/ready RV32I instruction encoder with auto-incrementing word address.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  input  logic              clr
);

  req_t              in_req, s1_req_q;
  logic              s1_valid_q, out_valid_q, out_err_q;
  logic [31:0]       out_inst_q, p_inst;
  logic              p_err, s2_load, out_fire;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign in_req   = '{fmt_e'(in_fmt), in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm};
  assign out_fire = out_valid_q && out_ready;
  assign s2_load  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_load;
  // clr takes priority over the handshake increment.
  assign addr_d   = clr ? BASE_ADDR : out_fire ? addr_q + 1'b1 : addr_q;

  inst_pack u_pack (
    .req_i  (s1_req_q),
    .inst_o (p_inst),
    .err_o  (p_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_req_q    <= '0;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_err_q   <= 1'b0;
      addr_q      <= BASE_ADDR;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (in_valid && in_ready) s1_req_q <= in_req;
      if (s2_load) begin
        out_valid_q <= s1_valid_q;
        out_inst_q  <= s1_valid_q ? p_inst : '0;
        out_err_q   <= s1_valid_q && p_err;
      end
      addr_q <= addr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_err   = out_err_q;
  assign out_addr  = addr_q;

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: scoreboard bench with directed test-plan vectors and a randomized run against an arithmetic model.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  localparam int             AW   = 2;
  localparam logic [AW-1:0]  BASE = '0;

  logic          clk, rst_n, in_valid, in_ready, out_valid, out_ready, out_err, clr;
  logic [31:0]   out_inst;
  logic [AW-1:0] out_addr;
  req_t          cur;

  inst_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (cur.fmt),
    .in_opcode (cur.opcode),
    .in_rd     (cur.rd),
    .in_rs1    (cur.rs1),
    .in_rs2    (cur.rs2),
    .in_funct3 (cur.funct3),
    .in_funct7 (cur.funct7),
    .in_imm    (cur.imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .clr       (clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int            errors = 0;
  int            checks = 0;
  logic [31:0]   q_inst[$];
  logic          q_err[$];
  logic [AW-1:0] exp_addr;
  int            bnd[14] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4098,
                             1048574, 1048576, -1048576, -1048578, 32};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected completion at %0t", name, $time);
  endtask

  // Expected word derived arithmetically from the RV32I field placement rules.
  function automatic logic [32:0] model(input req_t r);
    logic [31:0] u, rd, f3, r1, r2, op;
    int s;
    u  = r.imm;
    s  = $signed(r.imm);
    rd = 32'(r.rd) << 7;
    f3 = 32'(r.funct3) << 12;
    r1 = 32'(r.rs1) << 15;
    r2 = 32'(r.rs2) << 20;
    op = 32'(r.opcode);
    case (r.fmt)
      FMT_R:   return {1'b0, (32'(r.funct7) << 25) | r2 | r1 | f3 | rd | op};
      FMT_I:   return {s < -2048 || s > 2047, ((u & 32'hFFF) << 20) | r1 | f3 | rd | op};
      FMT_ISH: return {(u >> 5) != 0, (32'(r.funct7) << 25) | ((u & 32'h1F) << 20) | r1 | f3 | rd | op};
      FMT_S:   return {s < -2048 || s > 2047,
                       (((u >> 5) & 32'h7F) << 25) | r2 | r1 | f3 | ((u & 32'h1F) << 7) | op};
      FMT_B:   return {s < -4096 || s > 4094 || (u & 32'h1) != 0,
                       (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | r2 | r1 | f3 |
                       (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7) | op};
      FMT_U:   return {(u & 32'hFFF) != 0, (u & 32'hFFFFF000) | rd | op};
      FMT_J:   return {s < -1048576 || s > 1048574 || (u & 32'h1) != 0,
                       (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
                       (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12) | rd | op};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  function automatic req_t mk(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm);
    return '{fmt_e'(f), op, rd, rs1, rs2, f3, f7, imm};
  endfunction

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 5))
      0: return $urandom;
      1: return 32'(int'($urandom_range(0, 10000)) - 5000);
      2: return 32'(int'($urandom_range(0, 2100000)) - 1050000);
      3: return 32'(bnd[$urandom_range(0, 13)]);
      4: return $urandom & 32'hFFFFF000;
      default: return 32'($urandom_range(0, 40));
    endcase
  endfunction

  task automatic mon();
    if (!rst_n) exp_addr = BASE;
    else begin
      if (out_valid && out_ready) begin
        if (q_inst.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h expected none", out_inst);
        end else begin
          chk("inst", out_inst, q_inst.pop_front());
          chk("err", 32'(out_err), 32'(q_err.pop_front()));
          chk("addr", 32'(out_addr), 32'(exp_addr));
        end
      end
      exp_addr = clr ? BASE : (out_valid && out_ready) ? exp_addr + 1'b1 : exp_addr;
    end
  endtask

  task automatic send(input req_t r, input logic [31:0] ei, input logic ee);
    logic ok;
    ok       = 1'b0;
    cur      = r;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        q_inst.push_back(ei);
        q_err.push_back(ee);
        ok = 1'b1;
      end
    end
    #1 in_valid = 1'b0;
    if (!ok) fail("send");
  endtask

  task automatic send_rand();
    req_t r;
    logic [32:0] m;
    r = mk(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           3'($urandom), 7'($urandom), rand_imm());
    m = model(r);
    send(r, m[31:0], m[32]);
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && q_inst.size() != 0; n++) @(posedge clk);
    #1;
    if (q_inst.size() != 0) fail("drain");
  endtask

  task automatic do_reset();
    q_inst.delete();
    q_err.delete();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [31:0]   snap_inst;
  logic [AW-1:0] snap_addr;
  logic          bg_done, rnd_done;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clr       = 1'b0;
    cur       = '0;
    exp_addr  = BASE;
    fork
      forever begin
        @(negedge clk);
        mon();
      end
    join_none
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_err", 32'(out_err), 0);
    chk("rst_out_addr", 32'(out_addr), 32'(BASE));
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rst_in_ready", 32'(in_ready), 1);

    send(mk(1, OP_IMM, 1, 0, 31, 0, 7'h7F, 32'hFFFFFFFF), 32'hFFF00093, 1'b0);
    chk("latency_s1", 32'(out_valid), 0);
    send(mk(2, OP_STORE, 0, 3, 2, 2, 0, 8), 32'h0021A423, 1'b0);
    chk("latency_s2", 32'(out_valid), 1);
    send(mk(0, 7'h33, 3, 1, 2, 0, 0, 32'hDEADBEEF), 32'h002081B3, 1'b0);
    send(mk(6, OP_IMM, 1, 2, 0, 5, 7'h20, 3), 32'h40315093, 1'b0);
    send(mk(3, OP_BRANCH, 0, 0, 0, 0, 0, -32'sd4), 32'hFE000EE3, 1'b0);
    send(mk(5, OP_JAL, 1, 0, 0, 0, 0, 2048), 32'h001000EF, 1'b0);
    send(mk(4, OP_LUI, 5, 7, 9, 3, 7'h55, 32'h12345000), 32'h123452B7, 1'b0);
    send(mk(1, OP_IMM, 0, 0, 0, 0, 0, 2048), 32'h80000013, 1'b1);
    send(mk(3, OP_BRANCH, 0, 0, 0, 0, 0, 3), 32'h00000163, 1'b1);
    send(mk(4, OP_LUI, 0, 0, 0, 0, 0, 32'h12345001), 32'h12345037, 1'b1);
    send(mk(6, OP_IMM, 1, 2, 0, 5, 7'h20, 32), 32'h40015093, 1'b1);
    send(mk(7, 7'h7F, 31, 31, 31, 7, 7'h7F, 32'hFFFFFFFF), 32'h0, 1'b1);
    send(mk(1, OP_LOAD, 4, 5, 0, 2, 0, -32'sd2048), 32'h8002A203, 1'b0);
    drain();

    // clr during a handshake: second word must come out at BASE, not be lost.
    out_ready = 1'b0;
    send_rand();
    send_rand();
    out_ready = 1'b1;
    clr       = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    chk("clr_addr", 32'(out_addr), 32'(BASE));
    chk("clr_keep_valid", 32'(out_valid), 1);
    drain();

    do_reset();
    out_ready = 1'b0;
    send_rand();
    send_rand();
    chk("bp_in_ready", 32'(in_ready), 0);
    snap_inst = out_inst;
    snap_addr = out_addr;
    bg_done   = 1'b0;
    fork
      begin
        send_rand();
        bg_done = 1'b1;
      end
    join_none
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_hold_inst", out_inst, snap_inst);
      chk("bp_hold_addr", 32'(out_addr), 32'(snap_addr));
      chk("bp_hold_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    for (int n = 0; n < 50 && !bg_done; n++) @(posedge clk);
    if (!bg_done) fail("bp_third");
    drain();

    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) send_rand();
        rnd_done = 1'b1;
      end
    join_none
    for (int n = 0; n < 20000 && !rnd_done; n++) begin
      @(posedge clk);
      #1;
      out_ready = $urandom_range(0, 3) != 0;
      clr       = $urandom_range(0, 40) == 0;
    end
    if (!rnd_done) fail("random_run");
    out_ready = 1'b1;
    clr       = 1'b0;
    drain();

    // Reset mid-stream with both stages occupied and a non-base address.
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    send_rand();
    drain();
    out_ready = 1'b0;
    send_rand();
    send_rand();
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_inst", out_inst, 0);
    chk("mid_rst_err", 32'(out_err), 0);
    chk("mid_rst_addr", 32'(out_addr), 32'(BASE));
    q_inst.delete();
    q_err.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send_rand();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
